// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Owns the program counter and fetches one 32-bit word per cycle from a
// byte-addressed instruction memory with a combinational read. Each fetched
// word is stored with its PC in a small FIFO. The FIFO feeds decode through a
// valid/ready handshake.
//
// A redirect flushes the FIFO and restarts fetch at the new target. An illegal
// address parks the unit in FAULT. An illegal address is either a misaligned
// redirect target or one past the last word of memory. In FAULT no more words
// are fetched. The FIFO keeps draining, and only a legal redirect leaves FAULT.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   imem_addr        byte address to instruction memory (== fetch_pc)
//   imem_instr       word returned combinationally for imem_addr
//   redirect_valid   one-cycle pulse: flush and restart at redirect_target
//   redirect_target  new fetch byte address
//   out_valid        FIFO head is valid
//   out_ready        decode accepts the head this cycle
//   out_instr        head instruction, 0 when out_valid=0
//   out_pc           head PC, 0 when out_valid=0
//   fetch_fault      high while in FAULT
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          IMEM_BYTES  = 88,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_fault
);

    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - 4);
    localparam int          PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int          CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [63:0]        fetch_pc_reg, fetch_pc_next;

    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [63:0]        q_pc_reg    [QUEUE_DEPTH];
    logic [31:0]        q_instr_reg [QUEUE_DEPTH];

    logic               push, pop, flush, full, target_legal;

    // Pointers wrap explicitly so that depths other than powers of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid    = (count_reg != '0);
    assign full         = (count_reg == DEPTH_C);
    assign pop          = out_valid && out_ready;
    assign target_legal = (redirect_target[1:0] == 2'b00) && (redirect_target <= LAST_PC);

    // ------------------------------------------------------------------
    // FSM: state and fetch PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_FETCH;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, next PC and the FIFO controls
    // A redirect outranks everything else, including a pop in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        push          = 1'b0;
        flush         = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (target_legal) begin
                        fetch_pc_next = redirect_target;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end else if (fetch_pc_reg > LAST_PC) begin
                    state_next = ST_FAULT;
                end else if (!full || pop) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc_reg + 64'd4;
                end
            end
            ST_FAULT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (target_legal) begin
                        state_next    = ST_FETCH;
                        fetch_pc_next = redirect_target;
                    end
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping. A push and a pop in the same cycle leave the count
    // unchanged, even when the FIFO is full.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= ptr_inc(tail_reg);
            if (pop)  head_reg <= ptr_inc(head_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage, one register pair per entry
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_pc_reg[gi]    <= '0;
                    q_instr_reg[gi] <= '0;
                end else if (push && (tail_reg == PTR_W'(gi))) begin
                    q_pc_reg[gi]    <= fetch_pc_reg;
                    q_instr_reg[gi] <= imem_instr;
                end
            end
        end
    endgenerate

    // The head is read straight from registers, so a newly pushed word
    // appears on the outputs one cycle later at the earliest.
    assign out_pc      = out_valid ? q_pc_reg[head_reg]    : 64'd0;
    assign out_instr   = out_valid ? q_instr_reg[head_reg] : 32'd0;
    assign imem_addr   = fetch_pc_reg;
    assign fetch_fault = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for instruction_fetch_unit.
// The stimulus queues every transaction that decode is expected to accept.
// A monitor running on the falling edge pops that queue on each handshake and
// compares. It also checks that idle outputs are zero and that the head holds
// steady while it is stalled. A handshake in a redirect cycle is flushed by the
// DUT, so it is not counted as an accept.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int IMEM_BYTES = 88;
    localparam int NWORDS     = IMEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] redirect_target = 64'd0;
    logic [63:0] imem_addr, out_pc;
    logic [31:0] imem_instr, out_instr;
    logic        out_valid, fetch_fault;

    logic [7:0]  imem [0:IMEM_BYTES-1];
    logic [31:0] prog [0:NWORDS-1];
    logic [15:0] ia;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } txn_t;
    txn_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // monitor state
    logic        hold_prev = 1'b0;
    logic [63:0] hold_pc   = 64'd0;
    logic [31:0] hold_instr = 32'd0;
    txn_t        mon_e;

    instruction_fetch_unit #(
        .RESET_PC   (64'd0),
        .IMEM_BYTES (IMEM_BYTES),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    initial forever #5 clk = ~clk;

    // Little-endian byte memory with a combinational read
    assign ia = imem_addr[15:0];
    always_comb begin
        imem_instr = 32'd0;
        if (imem_addr <= 64'(IMEM_BYTES - 4))
            imem_instr = {imem[ia + 16'd3], imem[ia + 16'd2], imem[ia + 16'd1], imem[ia]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int pc);
        txn_t e;
        e.pc    = 64'(pc);
        e.instr = prog[pc / 4];
        exp_q.push_back(e);
    endtask

    task automatic push_range(input int first, input int last);
        for (int p = first; p <= last; p += 4) push_exp(p);
    endtask

    task automatic redirect(input logic [63:0] tgt, input logic rdy);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        out_ready       = rdy;
        tick();
        redirect_valid  = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("stall_hold_valid", out_valid, 1);
                    check("stall_hold_pc", out_pc, hold_pc);
                    check("stall_hold_instr", out_instr, hold_instr);
                end
                if (!out_valid) begin
                    check("idle_pc_zero", out_pc, 0);
                    check("idle_instr_zero", out_instr, 0);
                end else if (out_ready && !redirect_valid) begin
                    check("accept_was_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        check("accept_pc", out_pc, mon_e.pc);
                        check("accept_instr", out_instr, 64'(mon_e.instr));
                        $display("txn: pc=%0d instr=0x%08h (expected pc=%0d instr=0x%08h)",
                                 out_pc, out_instr, mon_e.pc, mon_e.instr);
                    end
                end
                hold_prev  = out_valid && !out_ready && !redirect_valid;
                hold_pc    = out_pc;
                hold_instr = out_instr;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NWORDS; i++) prog[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0101;
        prog[0] = 32'h008484B3;
        prog[1] = 32'h009A84B3;
        prog[2] = 32'h00148493;
        prog[3] = 32'h00548493;
        for (int i = 0; i < NWORDS; i++)
            for (int b = 0; b < 4; b++)
                imem[4*i + b] = prog[i][8*b +: 8];

        // Reset state
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pc", out_pc, 0);
        check("reset_out_instr", out_instr, 0);
        check("reset_fetch_fault", fetch_fault, 0);
        check("reset_imem_addr", imem_addr, 0);
        tick();
        check("reset_hold_addr", imem_addr, 0);

        // Stream with out_ready=1 until the end of memory
        reset = 1'b0;
        out_ready = 1'b1;
        push_range(0, 84);
        for (int k = 1; k <= 22; k++) begin
            tick();
            check("stream_valid_continuous", out_valid, 1);
            if (k == 1) check("first_pc_after_reset", out_pc, 0);
        end
        tick();
        check("end_fault", fetch_fault, 1);
        check("end_valid_drained", out_valid, 0);
        check("end_imem_addr", imem_addr, 88);
        tick();
        tick();
        check("end_fault_sticky", fetch_fault, 1);
        check("end_addr_sticky", imem_addr, 88);
        check("end_all_accepted", exp_q.size(), 0);

        // Redirect to 0 clears the fault; then stall with out_ready=0
        redirect(64'd0, 1'b0);
        check("clear_fault", fetch_fault, 0);
        check("clear_valid_gap", out_valid, 0);
        check("clear_addr", imem_addr, 0);
        push_range(0, 12);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_out_pc", out_pc, 0);
            if (k >= 2) check("stall_imem_addr", imem_addr, 8);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        out_ready = 1'b0;
        check("stall_release_all_accepted", exp_q.size(), 0);

        // Fill with PCs 0 and 4, then redirect to 12 with out_ready=1
        redirect(64'd0, 1'b0);
        tick();
        tick();
        check("prefill_head_pc", out_pc, 0);
        check("prefill_addr", imem_addr, 8);
        push_range(12, 84);
        redirect(64'd12, 1'b1);
        check("redir_gap_valid", out_valid, 0);
        check("redir_addr", imem_addr, 12);
        tick();
        check("redir_target_valid", out_valid, 1);
        check("redir_target_pc", out_pc, 12);
        check("redir_target_instr", out_instr, 64'h00548493);
        for (int k = 0; k < 40 && !fetch_fault; k++) tick();
        check("redir_run_fault", fetch_fault, 1);
        check("redir_run_addr", imem_addr, 88);
        tick();
        tick();
        check("redir_run_drained", out_valid, 0);
        check("redir_run_all_accepted", exp_q.size(), 0);

        // Illegal redirects: misaligned, then out of range
        redirect(64'd0, 1'b0);
        tick();
        tick();
        check("ill_prefill_fault", fetch_fault, 0);
        redirect(64'd6, 1'b0);
        check("misaligned_fault", fetch_fault, 1);
        check("misaligned_flush", out_valid, 0);
        check("misaligned_pc_held", imem_addr, 8);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("fault_no_push", out_valid, 0);
        check("fault_pc_held", imem_addr, 8);
        redirect(64'd88, 1'b0);
        check("fault_oor_stays", fetch_fault, 1);
        check("fault_oor_pc_held", imem_addr, 8);
        redirect(64'd0, 1'b0);
        check("legal_exit_fault", fetch_fault, 0);
        check("legal_exit_addr", imem_addr, 0);
        tick();
        tick();
        redirect(64'd88, 1'b0);
        check("oor_fault", fetch_fault, 1);
        check("oor_flush", out_valid, 0);
        check("oor_pc_held", imem_addr, 8);

        // Asynchronous reset while faulted
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_fault", fetch_fault, 0);
        check("async_reset_addr_f", imem_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("refill_valid", out_valid, 1);
        check("refill_addr", imem_addr, 8);

        // Asynchronous reset with the FIFO full
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_pc", out_pc, 0);
        check("async_reset_instr", out_instr, 0);
        check("async_reset_fault2", fetch_fault, 0);
        check("async_reset_addr", imem_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        push_range(0, 84);
        tick();
        check("restart_valid", out_valid, 1);
        check("restart_pc", out_pc, 0);
        for (int k = 0; k < 40 && !fetch_fault; k++) tick();
        check("restart_run_fault", fetch_fault, 1);
        tick();
        tick();
        check("restart_all_accepted", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Owns the program counter and sequences fetches from the byte-addressed, combinational-read instruction memory. The memory returns 4 little-endian bytes at the addressed location. Fetched words are buffered, with their PCs, in a small queue that feeds decode through a valid/ready handshake. The block also handles branch/jump redirects with a queue flush, and stops fetching on misaligned or out-of-range addresses.

Parameters:
RESET_PC, 0, byte address fetched first after reset; must be a multiple of 4
IMEM_BYTES, 88, size of the instruction memory in bytes; the last legal fetch address is IMEM_BYTES-4
QUEUE_DEPTH, 2, number of entries in the fetch queue; must be at least 2

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_addr  output  64  byte address to the instruction memory; equals fetch_pc
imem_instr  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  one-cycle pulse: flush the queue and restart fetch at redirect_target
redirect_target  input  64  new fetch byte address
out_valid  output  1  queue head is valid
out_ready  input  1  decode accepts the head this cycle
out_instr  output  32  instruction at the queue head; 0 when out_valid=0
out_pc  output  64  byte address of out_instr; 0 when out_valid=0
fetch_fault  output  1  high while in FAULT state

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - fetch_pc=RESET_PC, so imem_addr=RESET_PC
  - queue empty; out_valid=0, out_instr=0, out_pc=0
  - fetch_fault=0; state=FETCH
- State FETCH, each rising edge, in priority order:
  1. redirect_valid=1:
     - queue flushed (count=0), including any pop in the same cycle
     - no push this cycle
     - if redirect_target[1:0]!=0 or redirect_target>IMEM_BYTES-4: state=FAULT, fetch_pc unchanged
     - otherwise fetch_pc=redirect_target
  2. fetch_pc>IMEM_BYTES-4: state=FAULT, no push.
  3. queue not full, or full with a pop this cycle: push {fetch_pc, imem_instr}, then fetch_pc+=4.
  4. queue full and no pop: fetch_pc holds and no push (stall).
- State FAULT:
  - no pushes; fetch_pc holds; fetch_fault=1
  - queue keeps draining normally
  - a redirect to a legal target flushes the queue, returns to FETCH and sets fetch_pc=target
  - a redirect to an illegal target flushes the queue and stays in FAULT
- Handshake:
  - pop when out_valid&&out_ready at the rising edge
  - out_instr/out_pc are stable while out_valid=1 and out_ready=0
  - out_valid is a registered function of queue count (count!=0)
  - order is strict FIFO; the queue has no combinational bypass
- Latency:
  - the first instruction after reset is presented one cycle after reset deasserts (out_valid=1 after the first edge)
  - redirect at edge N: the target instruction is pushed at edge N+1 and presented after edge N+1
  - out_valid=0 for exactly the cycle between edges N and N+1
- Arithmetic:
  - fetch_pc is 64-bit unsigned; +4 wraps mod 2^64
  - the range check makes wrap unreachable for legal IMEM_BYTES
- Simultaneous events:
  - push and pop in the same cycle keep count unchanged, including when full
  - redirect overrides push and pop
- imem_addr is purely a function of fetch_pc; there is no combinational path from any input to imem_addr.

Test Plan:
- Memory holds 0x008484B3 @0, 0x009A84B3 @4, 0x00148493 @8, 0x00548493 @12; hold out_ready=1 after reset -> out_pc/out_instr = 0/0x008484B3, 4/0x009A84B3, 8/0x00148493, 12/0x00548493 on consecutive cycles, with out_valid=1 continuously from the first edge.
- Same memory, out_ready=0 for 5 cycles, then 1 -> queue fills at count=2, imem_addr stalls at 8 and out_pc stays 0; after release, PCs 0,4,8,12 in order with none lost or duplicated.
- Redirect to 12 while queue holds PCs 0 and 4, with out_ready=1 in the same cycle -> PCs 0 and 4 are never presented after that edge; out_valid=0 for one cycle, then out_pc=12, out_instr=0x00548493.
- Free-run with IMEM_BYTES=88 -> last pushed PC is 84; fetch_fault=1 with imem_addr=88; queue drains; out_valid=0 afterwards; redirect to 0 clears the fault and PC 0 is presented two edges later.
- Redirect to 6 (misaligned) and to 88 (out of range) -> queue flushed, fetch_fault=1, fetch_pc unchanged, no further pushes.
- Assert reset mid-stream with queue full -> out_valid, fetch_fault and out_pc drop to 0 immediately (no clock edge needed), imem_addr=0; after release, fetch restarts at PC 0.
